// File: rtl/waveform_meter.sv
// Rising-crossing period and peak meter for an 8-bit sample stream, with hysteresis.
// Optional macro METER_TIMEOUT_EN: drop lock and flag timeout when the period counter saturates.
module waveform_meter #(
    parameter logic [7:0] THRESH = 8'd128,
    parameter logic [7:0] HYST   = 8'd8,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [7:0]       sample_in,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       peak_max,
    output logic [7:0]       peak_min,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [8:0]       HI_SUM  = {1'b0, THRESH} + {1'b0, HYST};
    localparam logic [7:0]       LO      = (THRESH > HYST) ? THRESH - HYST : 8'd0;
    localparam logic [7:0]       HI      = HI_SUM[8] ? 8'hFF : HI_SUM[7:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {SEEK, RUN} state_e;

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       peak_max_q, peak_max_d;
    logic [7:0]       peak_min_q, peak_min_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             crossing;

    assign crossing = sample_valid && armed_q && (sample_in >= HI);

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        cnt_d        = cnt_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        period_d     = period_q;
        peak_max_d   = peak_max_q;
        peak_min_d   = peak_min_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;

        if (crossing) begin
            armed_d = 1'b0;
            // The crossing sample itself belongs to the period it closes.
            if (state_q == RUN) begin
                period_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                peak_max_d   = (sample_in > run_max_q) ? sample_in : run_max_q;
                peak_min_d   = (sample_in < run_min_q) ? sample_in : run_min_q;
                meas_valid_d = 1'b1;
                locked_d     = 1'b1;
                timeout_d    = 1'b0;
            end
            state_d   = RUN;
            cnt_d     = '0;
            run_max_d = 8'h00;
            run_min_d = 8'hFF;
        end else if (sample_valid) begin
            if (sample_in <= LO) armed_d = 1'b1;
            if (state_q == RUN) begin
                cnt_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                run_max_d = (sample_in > run_max_q) ? sample_in : run_max_q;
                run_min_d = (sample_in < run_min_q) ? sample_in : run_min_q;
`ifdef METER_TIMEOUT_EN
                // Counter range exhausted: the signal is lost, re-acquire from scratch.
                if (cnt_d == CNT_MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = SEEK;
                    armed_d   = 1'b0;
                end
`endif
            end
        end

`ifndef METER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SEEK;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            run_max_q    <= 8'h00;
            run_min_q    <= 8'hFF;
            period_q     <= '0;
            peak_max_q   <= 8'h00;
            peak_min_q   <= 8'h00;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            period_q     <= period_d;
            peak_max_q   <= peak_max_d;
            peak_min_q   <= peak_min_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign peak_max   = peak_max_q;
    assign peak_min   = peak_min_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_waveform_meter.sv
// Bench for waveform_meter: directed waveforms plus random streams against a sample-history model.
module tb_waveform_meter;

    localparam int CNT_W = 8;
    localparam int MAXC  = 255;
    localparam int LO    = 120;
    localparam int HI    = 136;
    localparam int VW    = CNT_W + 19;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_valid;
    logic [7:0]       sample_in;
    logic [CNT_W-1:0] period;
    logic [7:0]       peak_max;
    logic [7:0]       peak_min;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    waveform_meter #(.THRESH(8'd128), .HYST(8'd8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .period(period), .peak_max(peak_max), .peak_min(peak_min),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: samples since the last crossing are kept verbatim; period and peaks are taken from that history.
    bit m_armed, m_run, m_mv, m_locked, m_to;
    int m_period, m_pmax, m_pmin;
    int hist[$];

    logic [VW-1:0] act;
    assign act = {period, peak_max, peak_min, meas_valid, locked, timeout};

    function automatic logic [VW-1:0] exp_vec();
        logic [CNT_W-1:0] p;
        logic [7:0] mx, mn;
        p  = m_period[CNT_W-1:0];
        mx = m_pmax[7:0];
        mn = m_pmin[7:0];
        return {p, mx, mn, m_mv, m_locked, m_to};
    endfunction

    task automatic model_step(input bit rst, input bit v, input int s);
        int mx, mn;
        if (!rst) begin
            m_armed = 0; m_run = 0; m_mv = 0; m_locked = 0; m_to = 0;
            m_period = 0; m_pmax = 0; m_pmin = 0;
            hist.delete();
            return;
        end
        m_mv = 0;
        if (!v) return;
        if (m_armed && s >= HI) begin
            m_armed = 0;
            if (m_run) begin
                mx = s; mn = s;
                foreach (hist[k]) begin
                    if (hist[k] > mx) mx = hist[k];
                    if (hist[k] < mn) mn = hist[k];
                end
                m_period = (hist.size() + 1 > MAXC) ? MAXC : hist.size() + 1;
                m_pmax = mx; m_pmin = mn;
                m_mv = 1; m_locked = 1; m_to = 0;
            end
            m_run = 1;
            hist.delete();
        end else begin
            if (s <= LO) m_armed = 1;
            if (m_run) begin
                hist.push_back(s);
`ifdef METER_TIMEOUT_EN
                if (hist.size() == MAXC) begin
                    m_to = 1; m_locked = 0; m_run = 0; m_armed = 0;
                end
`endif
            end
        end
    endtask

    task automatic drive(input bit rst, input bit v, input logic [7:0] s);
        reset = rst; sample_valid = v; sample_in = s;
        @(posedge clk);
        #1;
        model_step(rst, v, int'(s));
        cyc++;
    endtask

    function automatic logic [7:0] sq(input int k);
        return ((k % 10) < 5) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [7:0] tri_s(input int k);
        int p;
        p = k % 16;
        if (p < 8) return 8'(p * 32);
        if (p == 8) return 8'd255;
        return 8'((16 - p) * 32);
    endfunction

    task automatic test_reset();
        logic [VW-1:0] zero;
        zero = '0;
        drive(0, 1, 8'd0);
        drive(0, 0, 8'd200);
        total++;
        if (act !== zero) begin bad++; $display("FAIL reset_state: got %h want %h", act, zero); end
        total++;
        if (act !== exp_vec()) begin bad++; $display("FAIL reset_model: got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_square();
        int pulses = 0;
        for (int k = 0; k < 60; k++) begin
            drive(1, 1, sq(k));
            if (meas_valid) pulses++;
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL square k=%0d: got %h want %h", k, act, exp_vec()); end
        end
        total++;
        if (period !== 8'd10 || peak_max !== 8'd255 || peak_min !== 8'd0 || locked !== 1'b1)
            begin bad++; $display("FAIL square_final: got p=%0d max=%0d min=%0d lk=%0b want 10/255/0/1", period, peak_max, peak_min, locked); end
        total++;
        if (pulses !== 5) begin bad++; $display("FAIL square_pulses: got %0d want 5", pulses); end
    endtask

    task automatic test_half_rate();
        int last = -1;
        int gaps_bad = 0;
        for (int k = 0; k < 60; k++) begin
            for (int h = 0; h < 2; h++) begin
                drive(1, (h == 0), (h == 0) ? sq(k) : 8'($urandom_range(0, 255)));
                total++;
                if (act !== exp_vec()) begin bad++; $display("FAIL half_rate k=%0d: got %h want %h", k, act, exp_vec()); end
                if (meas_valid) begin
                    if (last >= 0 && cyc - last != 20) gaps_bad++;
                    last = cyc;
                end
            end
        end
        total++;
        if (gaps_bad !== 0 || period !== 8'd10) begin bad++; $display("FAIL half_rate_spacing: got gaps_bad=%0d period=%0d want 0/10", gaps_bad, period); end
    endtask

    task automatic test_hold();
        int pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            drive(1, 1, (k % 2 == 0) ? 8'd125 : 8'd131);
            if (meas_valid) pulses++;
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL hold k=%0d: got %h want %h", k, act, exp_vec()); end
        end
        total++;
        if (pulses !== 0 || period !== 8'd10) begin bad++; $display("FAIL hold_quiet: got pulses=%0d period=%0d want 0/10", pulses, period); end
    endtask

    task automatic test_triangle();
        drive(0, 0, 8'd0);
        for (int k = 0; k < 64; k++) begin
            drive(1, 1, tri_s(k));
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL triangle k=%0d: got %h want %h", k, act, exp_vec()); end
        end
        total++;
        if (period !== 8'd16 || peak_max !== 8'd255 || peak_min !== 8'd0)
            begin bad++; $display("FAIL triangle_final: got p=%0d max=%0d min=%0d want 16/255/0", period, peak_max, peak_min); end
    endtask

    task automatic test_reset_mid();
        int first_p = -1;
        int crossings = 0;
        for (int k = 0; k < 33; k++) drive(1, 1, sq(k));
        drive(0, 1, 8'd255);
        total++;
        if (act !== '0) begin bad++; $display("FAIL reset_mid_state: got %h want 0", act); end
        for (int k = 33; k < 80; k++) begin
            drive(1, 1, sq(k));
            if (sq(k) == 8'd255 && sq(k - 1) == 8'd0) crossings++;
            if (meas_valid && first_p < 0) first_p = period;
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL reset_mid k=%0d: got %h want %h", k, act, exp_vec()); end
            if (crossings < 2) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL reset_mid_unlocked k=%0d: got %0b want 0", k, locked); end
            end
        end
        total++;
        if (first_p !== 10) begin bad++; $display("FAIL reset_mid_first_period: got %0d want 10", first_p); end
    endtask

    task automatic test_timeout();
        drive(0, 0, 8'd0);
        for (int k = 0; k < 5; k++) drive(1, 1, 8'd0);
        drive(1, 1, 8'd255);
        for (int k = 0; k < 5; k++) drive(1, 1, 8'd0);
        drive(1, 1, 8'd255);
        total++;
        if (period !== 8'd6 || locked !== 1'b1) begin bad++; $display("FAIL timeout_lock: got p=%0d lk=%0b want 6/1", period, locked); end
        for (int k = 0; k < 254; k++) drive(1, 1, 8'd0);
        total++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL timeout_early: got to=%0b lk=%0b want 0/1", timeout, locked); end
        drive(1, 1, 8'd0);
`ifdef METER_TIMEOUT_EN
        total++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL timeout_fire: got to=%0b lk=%0b want 1/0", timeout, locked); end
`else
        total++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL timeout_off: got to=%0b lk=%0b want 0/1", timeout, locked); end
`endif
        for (int k = 0; k < 10; k++) drive(1, 1, 8'd0);
        drive(1, 1, 8'd255);
        total++;
        if (act !== exp_vec()) begin bad++; $display("FAIL timeout_resume1: got %h want %h", act, exp_vec()); end
`ifndef METER_TIMEOUT_EN
        total++;
        if (period !== 8'hFF || meas_valid !== 1'b1) begin bad++; $display("FAIL sat_period: got p=%0d mv=%0b want 255/1", period, meas_valid); end
`endif
        for (int k = 0; k < 5; k++) drive(1, 1, 8'd0);
        drive(1, 1, 8'd255);
        total++;
        if (period !== 8'd6 || meas_valid !== 1'b1 || timeout !== 1'b0 || locked !== 1'b1)
            begin bad++; $display("FAIL timeout_clear: got p=%0d mv=%0b to=%0b lk=%0b want 6/1/0/1", period, meas_valid, timeout, locked); end
    endtask

    task automatic test_random();
        logic [7:0] s;
        bit v, r;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 5))
                0: s = 8'($urandom_range(0, 119));
                1: s = 8'($urandom_range(137, 255));
                2: s = 8'($urandom_range(119, 137));
                3: s = 8'd120;
                4: s = 8'd136;
                default: s = 8'($urandom_range(0, 255));
            endcase
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 499) != 0);
            drive(r, v, s);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL random k=%0d: got %h want %h", k, act, exp_vec()); end
        end
    endtask

    initial begin
        reset = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
        test_reset();
        test_square();
        test_half_rate();
        test_hold();
        test_triangle();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/waveform_meter.md
# waveform_meter

Receive-side measurement block for the waveform generator's 8-bit sample stream. It detects rising threshold crossings with hysteresis. For each full waveform period it reports the period in samples and the peak maximum and minimum. It sits downstream of the generator output, so self-checking benches and on-board readback can confirm the selected function, frequency load and shift amount.

## Interface
Parameters:
- THRESH, 8'd128, crossing midpoint
- HYST, 8'd8, hysteresis half-width
- CNT_W, 16, period counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- sample_valid  in  1  sample_in is a new sample this cycle
- sample_in  in  8  unsigned waveform sample
- period  out  CNT_W  last measured period, in valid samples
- peak_max  out  8  maximum sample of last period
- peak_min  out  8  minimum sample of last period
- meas_valid  out  1  one-cycle pulse: period/peak_* just updated
- locked  out  1  at least one full period measured since reset/loss
- timeout  out  1  no crossing within counter range (see Configuration)

## Operation
- Thresholds:
  - LO = THRESH−HYST, saturating at 0.
  - HI = THRESH+HYST, saturating at 255.
  - Defaults: LO=120, HI=136.
- Arm/cross rule:
  - Sample ≤ LO sets the internal armed flag.
  - A rising crossing is a valid sample ≥ HI while armed; it clears armed.
  - Samples strictly between LO and HI never change armed.
- Only cycles with sample_valid=1 are processed. With sample_valid=0, all state and outputs hold, except meas_valid, which is 0.
- FSM states:
  - SEEK: waits for first crossing; counter not running. First crossing → RUN.
  - RUN, on each valid non-crossing sample:
    - cnt ← cnt+1, saturating at 2^CNT_W−1.
    - run_max and run_min updated with the sample.
  - RUN, on each crossing sample s_j:
    - period ← cnt+1, saturating at all-ones.
    - peak_max ← max(run_max, s_j); peak_min ← min(run_min, s_j).
    - meas_valid ← 1; locked ← 1.
    - Restart: cnt ← 0, run_max ← 0, run_min ← 255.
- Entering RUN from SEEK does the same restart but produces no measurement.
- Period definition: crossings on valid samples i and j give period = j−i. Peaks cover samples i+1..j.
- Arithmetic is unsigned throughout; no wrap-around, saturation only.

## Timing
- All outputs are registered.
- meas_valid rises the cycle after the crossing sample's clk edge; latency is 1 clock. It lasts exactly one cycle.
- A crossing sample and its measurement update on the same edge. No back-to-back hazards: the earliest next crossing is 2 valid samples later.
- Reset (reset=0 at a rising edge):
  - state=SEEK, armed=0, cnt=0, run_max=0, run_min=255.
  - period=0, peak_max=0, peak_min=0, meas_valid=0, locked=0, timeout=0.
- Reset overrides sample_valid and discards any in-progress period. The first measurement after reset needs two crossings.

## Configuration
- METER_TIMEOUT_EN defined:
  - In RUN, when cnt reaches 2^CNT_W−1 without a crossing: timeout ← 1, locked ← 0, state ← SEEK, armed ← 0.
  - timeout is sticky until the next measurement (meas_valid) or reset.
- METER_TIMEOUT_EN undefined:
  - timeout is tied to 0.
  - cnt saturates; the next crossing reports period = all-ones and locked stays 1.

## Test plan
- Square wave, 5 samples 0 then 5 samples 255, sample_valid=1 continuously:
  - No meas_valid at the 1st crossing.
  - At the 2nd crossing and every 10 cycles after: period=10, peak_max=255, peak_min=0, locked=1.
- Same square wave with sample_valid asserted every other cycle → period=10, and meas_valid pulses every 20 clocks.
- Alternating samples 125, 131 for 1000 samples after lock → no meas_valid; outputs hold their previous values.
- Triangle 0,32,…,224,255,224,…,32 (16-sample period) → period=16, peak_max=255, peak_min=0.
- reset=0 for one cycle mid-period, then the square wave resumes:
  - All outputs take their reset values.
  - locked=0 until the second post-reset crossing.
  - The first period reported is 10.
- METER_TIMEOUT_EN, CNT_W=8: lock on the square wave, then hold the input at 0:
  - timeout=1 and locked=0 after 255 valid samples.
  - Resuming the square wave clears timeout on the next meas_valid.
